// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) constants for the inverse column mixer.
// Also holds the control FSM encoding and the xtime primitive.
package aes_pkg;

    typedef logic [15:0][7:0] state_t;
    typedef logic [3:0][7:0]  col_t;

    localparam logic [7:0] INV_COEF_E = 8'h0e;
    localparam logic [7:0] INV_COEF_B = 8'h0b;
    localparam logic [7:0] INV_COEF_D = 8'h0d;
    localparam logic [7:0] INV_COEF_9 = 8'h09;
    localparam logic [7:0] GF_POLY    = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_one_column.sv
// Combinational InvMixColumns for a single column; i_col[3] is a0 (row 0).
// Every coefficient is a sum of x, x2, x4, x8 terms, so no tables are needed.
module inv_mix_one_column
    import aes_pkg::*;
(
    input  col_t i_col,
    output col_t o_col
);

    logic [7:0] w_a  [4];
    logic [7:0] w_x2 [4];
    logic [7:0] w_x4 [4];
    logic [7:0] w_x8 [4];

    // Coefficient seen by input byte j in output row r, indexed by (j - r) mod 4.
    function automatic logic [7:0] coef_at(input logic [1:0] k);
        case (k)
            2'd0:    return INV_COEF_E;
            2'd1:    return INV_COEF_B;
            2'd2:    return INV_COEF_D;
            default: return INV_COEF_9;
        endcase
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] a, input logic [7:0] x2,
                                         input logic [7:0] x4, input logic [7:0] x8,
                                         input logic [7:0] k);
        return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_a[j]  = i_col[3-j];
            w_x2[j] = xtime(w_a[j]);
            w_x4[j] = xtime(w_x2[j]);
            w_x8[j] = xtime(w_x4[j]);
        end
    end

    always_comb begin
        o_col = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                o_col[3-r] = o_col[3-r] ^ scale(w_a[j], w_x2[j], w_x4[j], w_x8[j], coef_at(2'(j - r)));
            end
        end
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: one column per clock through a shared column unit.
// Handshakes: a transfer happens on a port in any cycle where valid and ready are both 1.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NCOL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0][7:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0][7:0] out_data,
    output logic [1:0]       dbg_state
);

    localparam int            CW       = $clog2(NCOL);
    localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

    fsm_state_t    r_state;
    fsm_state_t    w_next;
    logic [CW-1:0] r_col;
    state_t        r_work;
    state_t        r_result;
    col_t          w_col_in;
    col_t          w_col_out;
    logic          w_accept;

    assign w_accept  = in_valid & in_ready;
    assign out_data  = r_result;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_BUSY;
            ST_BUSY: if (r_col == LAST_COL) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = w_accept ? ST_BUSY : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // in_ready in DONE follows out_ready so a new state can enter as the result leaves.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        if (reset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    always_comb begin
        w_col_in = '0;
        for (int i = 0; i < 4; i++) begin
            w_col_in[3-i] = r_work[4'(15 - 4*i) - 4'(r_col)];
        end
    end

    inv_mix_one_column u_col (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_work   <= '0;
            r_result <= '0;
            r_col    <= '0;
        end else if (w_accept) begin
            r_work <= in_data;
            r_col  <= '0;
        end else if (r_state == ST_BUSY) begin
            for (int i = 0; i < 4; i++) begin
                r_result[4'(15 - 4*i) - 4'(r_col)] <= w_col_out[3-i];
            end
            if (r_col != LAST_COL) r_col <= r_col + 1'b1;
        end
    end

endmodule
